draw_rect_physics_ctl: RTL and testbench

//  Parametrised successor of the rectangle position controller. It sits between mouse_ctl and

---
 rtl/draw_rect_physics_ctl.sv | 165 ++++++++++++++++
 tb/tb_draw_rect_physics_ctl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/draw_rect_physics_ctl.sv
// rtl/draw_rect_physics_ctl.sv - rectangle follows mouse, drops on click, falls and bounces to rest
module draw_rect_physics_ctl #(
  parameter int SCREEN_W   = 800,
  parameter int SCREEN_H   = 600,
  parameter int RECT_W     = 48,
  parameter int RECT_H     = 64,
  parameter int COORD_W    = 12,
  parameter int FRAC_W     = 8,
  parameter int TICK_DIV   = 65000,
  parameter int ACCEL      = 16,
  parameter int DAMP_SHIFT = 1,
  parameter int REST_VEL   = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mouse_left,
  input  logic [COORD_W-1:0] mouse_x_position,
  input  logic [COORD_W-1:0] mouse_y_position,
  output logic [COORD_W-1:0] xpos,
  output logic [COORD_W-1:0] ypos,
  output logic [1:0]         state,
  output logic               at_rest
);

  localparam int ACC_W = COORD_W + FRAC_W;
  localparam int CNT_W = $clog2(TICK_DIV);

  localparam logic [COORD_W-1:0] FLOOR     = COORD_W'(SCREEN_H - RECT_H);
  localparam logic [COORD_W-1:0] XMAX      = COORD_W'(SCREEN_W - RECT_W);
  localparam logic [ACC_W-1:0]   ACCEL_V   = ACC_W'(ACCEL);
  localparam logic [ACC_W-1:0]   REST_V    = ACC_W'(REST_VEL);
  localparam logic [ACC_W-1:0]   FLOOR_ACC = {FLOOR, {FRAC_W{1'b0}}};
  localparam logic [CNT_W-1:0]   TICK_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_FOLLOW = 2'b00,
    ST_FALL   = 2'b01,
    ST_RISE   = 2'b10,
    ST_REST   = 2'b11
  } state_t;

  state_t             st, st_next;
  logic [ACC_W-1:0]   y_acc, y_acc_next;
  logic [ACC_W-1:0]   vel, vel_next;
  logic [COORD_W-1:0] xpos_next, ypos_next;
  logic               mouse_left_d;
  logic               click;
  logic               tick;
  logic [CNT_W-1:0]   tick_cnt;

  // Extra top bit on the sums catches overflow so the floor test and the
  // velocity saturation never see a wrapped value.
  logic [ACC_W:0]     fall_sum;
  logic [ACC_W:0]     vel_inc;
  logic [ACC_W-1:0]   vel_damped;
  logic [ACC_W-1:0]   rise_acc;

  assign click      = mouse_left & ~mouse_left_d;
  assign tick       = (tick_cnt == TICK_LAST);
  assign fall_sum   = {1'b0, y_acc} + {1'b0, vel};
  assign vel_inc    = {1'b0, vel} + {1'b0, ACCEL_V};
  assign vel_damped = vel >> DAMP_SHIFT;
  // Moving up past the top edge pins the accumulator at zero instead of wrapping.
  assign rise_acc   = (vel >= y_acc) ? '0 : (y_acc - vel);

  assign state   = st;
  assign at_rest = (st == ST_REST);

  // Register stage: FSM state, position, physics accumulators and click edge detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= ST_FOLLOW;
      xpos         <= '0;
      ypos         <= '0;
      y_acc        <= '0;
      vel          <= '0;
      mouse_left_d <= 1'b0;
    end else begin
      st           <= st_next;
      xpos         <= xpos_next;
      ypos         <= ypos_next;
      y_acc        <= y_acc_next;
      vel          <= vel_next;
      mouse_left_d <= mouse_left;
    end
  end

  // Physics tick divider; restarts on every state change so the first step lands TICK_DIV clocks in.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (st_next != st || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  // Next-state and datapath: a click outside FOLLOW always wins over a physics tick.
  always_comb begin
    st_next    = st;
    xpos_next  = xpos;
    ypos_next  = ypos;
    y_acc_next = y_acc;
    vel_next   = vel;
    case (st)
      ST_FOLLOW: begin
        if (click) begin
          st_next    = ST_FALL;
          vel_next   = '0;
          y_acc_next = {ypos, {FRAC_W{1'b0}}};
        end else begin
          xpos_next = (mouse_x_position > XMAX)  ? XMAX  : mouse_x_position;
          ypos_next = (mouse_y_position > FLOOR) ? FLOOR : mouse_y_position;
        end
      end
      ST_FALL: begin
        if (click) begin
          st_next  = ST_FOLLOW;
          vel_next = '0;
        end else if (tick) begin
          if (fall_sum[ACC_W:FRAC_W] >= {1'b0, FLOOR}) begin
            ypos_next  = FLOOR;
            y_acc_next = FLOOR_ACC;
            if (vel_damped >= REST_V) begin
              st_next  = ST_RISE;
              vel_next = vel_damped;
            end else begin
              st_next  = ST_REST;
              vel_next = '0;
            end
          end else begin
            y_acc_next = fall_sum[ACC_W-1:0];
            ypos_next  = fall_sum[ACC_W-1:FRAC_W];
            vel_next   = vel_inc[ACC_W] ? '1 : vel_inc[ACC_W-1:0];
          end
        end
      end
      ST_RISE: begin
        if (click) begin
          st_next  = ST_FOLLOW;
          vel_next = '0;
        end else if (tick) begin
          if (vel <= ACCEL_V) begin
            st_next  = ST_FALL;
            vel_next = '0;
          end else begin
            y_acc_next = rise_acc;
            ypos_next  = rise_acc[ACC_W-1:FRAC_W];
            vel_next   = vel - ACCEL_V;
          end
        end
      end
      ST_REST: begin
        if (click) begin
          st_next  = ST_FOLLOW;
          vel_next = '0;
        end else begin
          ypos_next = FLOOR;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_draw_rect_physics_ctl.sv
// tb/tb_draw_rect_physics_ctl.sv - randomized and directed checks of draw_rect_physics_ctl against a behavioural model
module tb_draw_rect_physics_ctl;

  localparam int SCREEN_W = 800;
  localparam int SCREEN_H = 600;
  localparam int RECT_W   = 48;
  localparam int RECT_H   = 64;
  localparam int FRAC     = 4;
  localparam int TDIV     = 4;
  localparam int ACC      = 16;
  localparam int DSH      = 1;
  localparam int RVEL     = 64;
  localparam int FLOOR    = SCREEN_H - RECT_H;
  localparam int XMAX     = SCREEN_W - RECT_W;
  localparam int VEL_MAX  = (1 << (12 + FRAC)) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mouse_left = 1'b0;
  logic [11:0] mouse_x = 12'd100;
  logic [11:0] mouse_y = 12'd200;
  logic [11:0] xpos, ypos;
  logic [1:0]  state;
  logic        at_rest;

  int checks = 0;
  int errors = 0;

  draw_rect_physics_ctl #(
    .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .RECT_W(RECT_W), .RECT_H(RECT_H),
    .COORD_W(12), .FRAC_W(FRAC), .TICK_DIV(TDIV), .ACCEL(ACC),
    .DAMP_SHIFT(DSH), .REST_VEL(RVEL)
  ) dut (
    .clk(clk), .rst(rst), .mouse_left(mouse_left),
    .mouse_x_position(mouse_x), .mouse_y_position(mouse_y),
    .xpos(xpos), .ypos(ypos), .state(state), .at_rest(at_rest)
  );

  always #5 clk = ~clk;

  // Behavioural model: position in 1/16 px units as plain integers.
  // Phases: 0 follow, 1 falling, 2 rising, 3 resting.
  int m_x, m_y, m_phase, m_vel, m_pos16, m_clk_in_phase;
  bit m_prev_left;
  bit model_ok = 1'b0;

  always @(posedge clk) begin
    bit press, step;
    int new_phase;
    if (rst) begin
      m_x = 0; m_y = 0; m_phase = 0; m_vel = 0; m_pos16 = 0;
      m_clk_in_phase = 0; m_prev_left = 0;
      model_ok = 1'b1;
    end else begin
      press = mouse_left && !m_prev_left;
      m_prev_left = mouse_left;
      step = ((m_clk_in_phase + 1) % TDIV) == 0;
      new_phase = m_phase;
      if (m_phase == 0) begin
        if (press) begin
          new_phase = 1; m_vel = 0; m_pos16 = m_y * 16;
        end else begin
          m_x = (int'(mouse_x) < XMAX) ? int'(mouse_x) : XMAX;
          m_y = (int'(mouse_y) < FLOOR) ? int'(mouse_y) : FLOOR;
        end
      end else if (press) begin
        new_phase = 0; m_vel = 0;
      end else if (m_phase == 3) begin
        m_y = FLOOR;
      end else if (step && m_phase == 1) begin
        if ((m_pos16 + m_vel) / 16 >= FLOOR) begin
          m_y = FLOOR; m_pos16 = FLOOR * 16;
          if ((m_vel / 2) >= RVEL) begin
            new_phase = 2; m_vel = m_vel / 2;
          end else begin
            new_phase = 3; m_vel = 0;
          end
        end else begin
          m_pos16 = m_pos16 + m_vel;
          m_y = m_pos16 / 16;
          m_vel = (m_vel + ACC > VEL_MAX) ? VEL_MAX : m_vel + ACC;
        end
      end else if (step && m_phase == 2) begin
        if (m_vel <= ACC) begin
          new_phase = 1; m_vel = 0;
        end else begin
          m_pos16 = (m_vel >= m_pos16) ? 0 : m_pos16 - m_vel;
          m_y = m_pos16 / 16;
          m_vel = m_vel - ACC;
        end
      end
      if (new_phase != m_phase) m_clk_in_phase = 0;
      else m_clk_in_phase = m_clk_in_phase + 1;
      m_phase = new_phase;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      checks++;
      if (int'(xpos) != m_x || int'(ypos) != m_y || int'(state) != m_phase ||
          at_rest != (m_phase == 3)) begin
        errors++;
        $display("FAIL model t=%0t dut x=%0d y=%0d st=%0d rest=%0d exp x=%0d y=%0d st=%0d",
                 $time, xpos, ypos, state, at_rest, m_x, m_y, m_phase);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic click_pulse();
    mouse_left = 1'b1;
    @(negedge clk);
    mouse_left = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int waited;
    int t01, to_follow, prev;

    // Reset state and first tracked position
    repeat (2) @(negedge clk);
    chk("rst_xpos", int'(xpos), 0);
    chk("rst_ypos", int'(ypos), 0);
    chk("rst_state", int'(state), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("follow_x", int'(xpos), 100);
    chk("follow_y", int'(ypos), 200);

    // Clamping
    mouse_x = 12'd900; mouse_y = 12'd590;
    @(negedge clk);
    chk("clamp_x", int'(xpos), 752);
    chk("clamp_y", int'(ypos), 536);

    // Drop from the top: parabolic fall, impact on tick 34
    mouse_x = 12'd100; mouse_y = 12'd0;
    repeat (2) @(negedge clk);
    mouse_left = 1'b1;
    @(negedge clk);
    chk("drop_state", int'(state), 1);
    chk("drop_x", int'(xpos), 100);
    for (int n = 1; n <= 33; n++) begin
      repeat (TDIV) @(negedge clk);
      chk($sformatf("fall_tick%0d", n), int'(ypos), n * (n - 1) / 2);
    end
    repeat (TDIV) @(negedge clk);
    chk("impact_y", int'(ypos), 536);
    chk("impact_state", int'(state), 2);
    chk("impact_x", int'(xpos), 100);
    mouse_left = 1'b0;

    // Bounces settle
    waited = 0;
    while (state != 2'd3 && waited < 20000) begin
      @(negedge clk);
      waited++;
    end
    chk("reach_rest", int'(state), 3);
    repeat (1000) @(negedge clk);
    chk("rest_flag", int'(at_rest), 1);
    chk("rest_y", int'(ypos), 536);

    // Regrab from rest
    mouse_x = 12'd300; mouse_y = 12'd400;
    click_pulse();
    @(negedge clk);
    chk("regrab_state", int'(state), 0);
    chk("regrab_x", int'(xpos), 300);
    chk("regrab_y", int'(ypos), 400);

    // Held button fires once only
    t01 = 0; to_follow = 0; prev = int'(state);
    mouse_left = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (prev == 0 && state == 2'd1) t01++;
      if (prev != 0 && state == 2'd0) to_follow++;
      prev = int'(state);
    end
    mouse_left = 1'b0;
    chk("held_one_drop", t01, 1);
    chk("held_no_regrab", to_follow, 0);

    // Random mouse activity against the model
    repeat (4000) begin
      @(negedge clk);
      mouse_x = 12'($urandom_range(0, 1023));
      mouse_y = 12'($urandom_range(0, 1023));
      if ($urandom_range(0, 39) == 0) mouse_left = ~mouse_left;
    end

    // Reset mid-fall
    mouse_left = 1'b0;
    repeat (2) @(negedge clk);
    if (state != 2'd0) click_pulse();
    mouse_x = 12'd200; mouse_y = 12'd0;
    repeat (3) @(negedge clk);
    click_pulse();
    waited = 0;
    while (ypos < 12'd300 && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    chk("midfall_reached", int'(ypos >= 12'd300), 1);
    chk("midfall_state", int'(state), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_x", int'(xpos), 0);
    chk("mrst_y", int'(ypos), 0);
    chk("mrst_state", int'(state), 0);
    chk("mrst_rest", int'(at_rest), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
